// File: rtl/sdram_pkg.sv
// Shared state encoding and widths for the SDRAM burst scheduler.
package sdram_pkg;

  localparam int ADDR_W     = 23;
  localparam int LEN_W      = 9;
  localparam int WDOG_LIMIT = 1024;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    WR_REQ,
    WR_DATA,
    RD_REQ,
    RD_DATA
  } sched_state_t;

endpackage

// File: rtl/sdram_burst_ptr.sv
// Circular burst index for one direction of the SDRAM region; turns the
// index into a word address BASE_ADDR + index*BURST_LEN.
module sdram_burst_ptr
  import sdram_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR    = 23'd0,
  parameter int                DEPTH_BURSTS = 64,
  parameter int                BURST_LEN    = 256
) (
  input  logic              clk,
  input  logic              sys_rst_n,
  input  logic              i_clear,
  input  logic              i_advance,
  output logic [ADDR_W-1:0] o_addr
);

  localparam int IDX_W = $clog2(DEPTH_BURSTS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DEPTH_BURSTS - 1);

  logic [IDX_W-1:0]  r_index;
  logic [ADDR_W-1:0] w_offset;

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_index <= '0;
    end else if (i_clear) begin
      r_index <= '0;
    end else if (i_advance) begin
      r_index <= (r_index == IDX_LAST) ? '0 : r_index + IDX_W'(1);
    end
  end

  // The largest region (32768 x 256 words) still fits in the 23-bit space.
  assign w_offset = ADDR_W'(r_index) * ADDR_W'(BURST_LEN);
  assign o_addr   = BASE_ADDR + w_offset;

endmodule

// File: rtl/sdram_burst_sched.sv
// Schedules write/read bursts between the FIFOs and a circular SDRAM region.
// Define SDRAM_SCHED_WATCHDOG_EN to abort requests that never see an ack.
module sdram_burst_sched
  import sdram_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR    = 23'd0,
  parameter int                DEPTH_BURSTS = 64,
  parameter int                BURST_LEN    = 256
) (
  input  logic              clk,
  input  logic              sys_rst_n,
  input  logic              sdram_init_done,
  input  logic              flush,
  input  logic              rd_enable,
  input  logic [9:0]        wr_fifo_used,
  input  logic [9:0]        rd_fifo_free,
  output logic              sdram_wr_req,
  output logic              sdram_rd_req,
  input  logic              sdram_wr_ack,
  input  logic              sdram_rd_ack,
  output logic [ADDR_W-1:0] sys_wraddr,
  output logic [ADDR_W-1:0] sys_rdaddr,
  output logic [LEN_W-1:0]  sdwr_byte,
  output logic [LEN_W-1:0]  sdrd_byte,
  output logic              wr_fifo_rd,
  output logic              rd_fifo_wr,
  output logic              busy,
  output logic [15:0]       level,
  output logic              timeout_err
);

  localparam logic [9:0]       FIFO_THRESH = 10'(BURST_LEN);
  localparam logic [15:0]      LEVEL_MAX   = 16'(DEPTH_BURSTS);
  localparam logic [LEN_W-1:0] LAST_ACK    = LEN_W'(BURST_LEN - 1);

  sched_state_t     r_state;
  logic             r_wrReq;
  logic             r_rdReq;
  logic             r_lastWasWr;
  logic [LEN_W-1:0] r_ackCnt;
  logic [15:0]      r_level;

  logic w_wrElig;
  logic w_rdElig;
  logic w_wrStrobe;
  logic w_rdStrobe;
  logic w_wrDone;
  logic w_rdDone;
  logic w_flushNow;
  logic w_wdogExpire;

  assign w_wrElig   = (wr_fifo_used >= FIFO_THRESH) && (r_level < LEVEL_MAX);
  assign w_rdElig   = rd_enable && (rd_fifo_free >= FIFO_THRESH) && (r_level != 16'd0);
  assign w_wrStrobe = sdram_wr_ack && ((r_state == WR_REQ) || (r_state == WR_DATA));
  assign w_rdStrobe = sdram_rd_ack && ((r_state == RD_REQ) || (r_state == RD_DATA));
  assign w_wrDone   = w_wrStrobe && (r_ackCnt == LAST_ACK);
  assign w_rdDone   = w_rdStrobe && (r_ackCnt == LAST_ACK);
  assign w_flushNow = flush && (r_state == IDLE);

`ifdef SDRAM_SCHED_WATCHDOG_EN
  localparam logic [9:0] WDOG_LAST = 10'(WDOG_LIMIT - 1);

  logic [9:0] r_wdogCnt;
  logic       r_timeoutErr;

  // Only the wait for the first ack is guarded; once data flows it is not.
  assign w_wdogExpire = (r_wdogCnt == WDOG_LAST) &&
                        (((r_state == WR_REQ) && !sdram_wr_ack) ||
                         ((r_state == RD_REQ) && !sdram_rd_ack));

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_wdogCnt    <= '0;
      r_timeoutErr <= 1'b0;
    end else begin
      if ((r_state == WR_REQ) || (r_state == RD_REQ)) begin
        r_wdogCnt <= r_wdogCnt + 10'd1;
      end else begin
        r_wdogCnt <= '0;
      end
      if (w_wdogExpire) begin
        r_timeoutErr <= 1'b1;
      end
    end
  end

  assign timeout_err = r_timeoutErr;
`else
  assign w_wdogExpire = 1'b0;
  assign timeout_err  = 1'b0;
`endif

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state     <= INIT;
      r_wrReq     <= 1'b0;
      r_rdReq     <= 1'b0;
      r_lastWasWr <= 1'b0;
      r_ackCnt    <= '0;
      r_level     <= '0;
    end else begin
      case (r_state)
        INIT: begin
          if (sdram_init_done) begin
            r_state <= IDLE;
          end
        end
        IDLE: begin
          r_ackCnt <= '0;
          // A flush wins over any pending decision in the same cycle.
          if (w_flushNow) begin
            r_level     <= '0;
            r_lastWasWr <= 1'b0;
          end else if (w_wrElig && !(w_rdElig && r_lastWasWr)) begin
            r_state     <= WR_REQ;
            r_wrReq     <= 1'b1;
            r_lastWasWr <= 1'b1;
          end else if (w_rdElig) begin
            r_state     <= RD_REQ;
            r_rdReq     <= 1'b1;
            r_lastWasWr <= 1'b0;
          end
        end
        WR_REQ, WR_DATA: begin
          if (w_wrStrobe) begin
            r_wrReq <= 1'b0;
            if (w_wrDone) begin
              r_state <= IDLE;
              r_level <= r_level + 16'd1;
            end else begin
              r_state  <= WR_DATA;
              r_ackCnt <= r_ackCnt + LEN_W'(1);
            end
          end else if (w_wdogExpire) begin
            r_wrReq <= 1'b0;
            r_state <= IDLE;
          end
        end
        RD_REQ, RD_DATA: begin
          if (w_rdStrobe) begin
            r_rdReq <= 1'b0;
            if (w_rdDone) begin
              r_state <= IDLE;
              r_level <= r_level - 16'd1;
            end else begin
              r_state  <= RD_DATA;
              r_ackCnt <= r_ackCnt + LEN_W'(1);
            end
          end else if (w_wdogExpire) begin
            r_rdReq <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= INIT;
      endcase
    end
  end

  sdram_burst_ptr #(
    .BASE_ADDR    (BASE_ADDR),
    .DEPTH_BURSTS (DEPTH_BURSTS),
    .BURST_LEN    (BURST_LEN)
  ) u_wrPtr (
    .clk       (clk),
    .sys_rst_n (sys_rst_n),
    .i_clear   (w_flushNow),
    .i_advance (w_wrDone),
    .o_addr    (sys_wraddr)
  );

  sdram_burst_ptr #(
    .BASE_ADDR    (BASE_ADDR),
    .DEPTH_BURSTS (DEPTH_BURSTS),
    .BURST_LEN    (BURST_LEN)
  ) u_rdPtr (
    .clk       (clk),
    .sys_rst_n (sys_rst_n),
    .i_clear   (w_flushNow),
    .i_advance (w_rdDone),
    .o_addr    (sys_rdaddr)
  );

  assign sdram_wr_req = r_wrReq;
  assign sdram_rd_req = r_rdReq;
  assign sdwr_byte    = LEN_W'(BURST_LEN);
  assign sdrd_byte    = LEN_W'(BURST_LEN);
  assign wr_fifo_rd   = w_wrStrobe;
  assign rd_fifo_wr   = w_rdStrobe;
  assign busy         = (r_state != IDLE);
  assign level        = r_level;

endmodule

// File: tb/tb_sdram_burst_sched.sv
// Self-checking bench for sdram_burst_sched (DEPTH_BURSTS=4, BURST_LEN=256);
// expected bursts are queued on stimulus and popped when a request rises.
module tb_sdram_burst_sched;

  localparam int BLEN = 256;

  logic        clk = 1'b0;
  logic        sys_rst_n;
  logic        sdram_init_done;
  logic        flush;
  logic        rd_enable;
  logic [9:0]  wr_fifo_used;
  logic [9:0]  rd_fifo_free;
  logic        sdram_wr_req;
  logic        sdram_rd_req;
  logic        sdram_wr_ack;
  logic        sdram_rd_ack;
  logic [22:0] sys_wraddr;
  logic [22:0] sys_rdaddr;
  logic [8:0]  sdwr_byte;
  logic [8:0]  sdrd_byte;
  logic        wr_fifo_rd;
  logic        rd_fifo_wr;
  logic        busy;
  logic [15:0] level;
  logic        timeout_err;

  int nCompared   = 0;
  int nMismatched = 0;

  typedef struct {
    bit          isWr;
    logic [22:0] addr;
  } exp_t;

  exp_t sbQ[$];

  typedef struct {
    int wrUsed;
    bit rdEn;
    int rdFree;
    int expKind;
    int expAddr;
    bit gapped;
    int expLevel;
  } vec_t;

  vec_t vecs[8];

  sdram_burst_sched #(
    .BASE_ADDR    (23'd0),
    .DEPTH_BURSTS (4),
    .BURST_LEN    (BLEN)
  ) dut (
    .clk             (clk),
    .sys_rst_n       (sys_rst_n),
    .sdram_init_done (sdram_init_done),
    .flush           (flush),
    .rd_enable       (rd_enable),
    .wr_fifo_used    (wr_fifo_used),
    .rd_fifo_free    (rd_fifo_free),
    .sdram_wr_req    (sdram_wr_req),
    .sdram_rd_req    (sdram_rd_req),
    .sdram_wr_ack    (sdram_wr_ack),
    .sdram_rd_ack    (sdram_rd_ack),
    .sys_wraddr      (sys_wraddr),
    .sys_rdaddr      (sys_rdaddr),
    .sdwr_byte       (sdwr_byte),
    .sdrd_byte       (sdrd_byte),
    .wr_fifo_rd      (wr_fifo_rd),
    .rd_fifo_wr      (rd_fifo_wr),
    .busy            (busy),
    .level           (level),
    .timeout_err     (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int act, input int exp);
    nCompared++;
    if (act != exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic curReq(input bit isWr);
    return isWr ? sdram_wr_req : sdram_rd_req;
  endfunction

  function automatic logic [22:0] curAddr(input bit isWr);
    return isWr ? sys_wraddr : sys_rdaddr;
  endfunction

  function automatic logic curStrobe(input bit isWr);
    return isWr ? wr_fifo_rd : rd_fifo_wr;
  endfunction

  task automatic setAck(input bit isWr, input logic val);
    if (isWr) sdram_wr_ack = val;
    else      sdram_rd_ack = val;
  endtask

  // Request rising edges pop the scoreboard and must match type and address.
  logic prevWr = 1'b0;
  logic prevRd = 1'b0;
  always @(negedge clk) begin
    if (sdram_wr_req && !prevWr) sbCompare(1'b1, sys_wraddr);
    if (sdram_rd_req && !prevRd) sbCompare(1'b0, sys_rdaddr);
    prevWr = sdram_wr_req;
    prevRd = sdram_rd_req;
  end

  task automatic sbCompare(input bit isWr, input logic [22:0] addr);
    exp_t e;
    if (sbQ.size() == 0) begin
      checkOutput("sb unexpected req", 1, 0);
    end else begin
      e = sbQ.pop_front();
      checkOutput("sb req type", int'(isWr), int'(e.isWr));
      checkOutput("sb req addr", int'(addr), int'(e.addr));
    end
  endtask

  // Waits for the request, serves BLEN acks (optionally 1 on / 1 off) and
  // checks strobes, request drop, address stability and return to IDLE.
  task automatic applyStimulus(input bit isWr, input bit gapped, input string tag);
    int waitCyc;
    int strobes;
    bit addrMoved;
    logic [22:0] addr0;
    waitCyc   = 0;
    strobes   = 0;
    addrMoved = 1'b0;
    while (!curReq(isWr) && waitCyc < 8) begin
      @(negedge clk);
      waitCyc++;
    end
    checkOutput({tag, " req seen"}, int'(curReq(isWr)), 1);
    addr0 = curAddr(isWr);
    for (int k = 0; k < BLEN; k++) begin
      if (k == 1) checkOutput({tag, " req dropped"}, int'(curReq(isWr)), 0);
      if (k == BLEN - 1) checkOutput({tag, " busy before last ack"}, int'(busy), 1);
      setAck(isWr, 1'b1);
      #1;
      strobes += int'(curStrobe(isWr));
      @(negedge clk);
      setAck(isWr, 1'b0);
      if (k < BLEN - 1) begin
        if (curAddr(isWr) != addr0) addrMoved = 1'b1;
        if (gapped) begin
          #1;
          strobes += int'(curStrobe(isWr));
          @(negedge clk);
        end
      end
    end
    checkOutput({tag, " strobes"}, strobes, BLEN);
    checkOutput({tag, " addr held"}, int'(addrMoved), 0);
    checkOutput({tag, " idle after burst"}, int'(busy), 0);
    checkOutput({tag, " req low after burst"}, int'(curReq(isWr)), 0);
  endtask

  initial begin
    repeat (60000) @(posedge clk);
    $display("[TB] FAIL global timeout: got running, expected finished");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    int waitCyc;
    int reqCyc;
    // wrUsed, rdEn, rdFree, kind(0 none/1 wr/2 rd), addr, gapped, level after
    vecs[0] = '{255,  1'b0, 0,    0, 0,   1'b0, 1};
    vecs[1] = '{0,    1'b1, 255,  0, 0,   1'b0, 1};
    vecs[2] = '{0,    1'b0, 512,  0, 0,   1'b0, 1};
    vecs[3] = '{0,    1'b1, 256,  2, 256, 1'b1, 0};
    vecs[4] = '{0,    1'b1, 512,  0, 0,   1'b0, 0};
    vecs[5] = '{256,  1'b0, 0,    1, 512, 1'b0, 1};
    vecs[6] = '{256,  1'b1, 256,  2, 512, 1'b1, 0};
    vecs[7] = '{1023, 1'b1, 1023, 1, 768, 1'b0, 1};

    sys_rst_n       = 1'b0;
    sdram_init_done = 1'b0;
    flush           = 1'b0;
    rd_enable       = 1'b0;
    wr_fifo_used    = 10'd0;
    rd_fifo_free    = 10'd0;
    sdram_wr_ack    = 1'b0;
    sdram_rd_ack    = 1'b0;

    repeat (3) @(negedge clk);
    checkOutput("reset wr_req", int'(sdram_wr_req), 0);
    checkOutput("reset rd_req", int'(sdram_rd_req), 0);
    checkOutput("reset wraddr", int'(sys_wraddr), 0);
    checkOutput("reset rdaddr", int'(sys_rdaddr), 0);
    checkOutput("reset level", int'(level), 0);
    checkOutput("reset busy", int'(busy), 1);
    checkOutput("reset timeout_err", int'(timeout_err), 0);
    checkOutput("sdwr_byte", int'(sdwr_byte), BLEN);
    checkOutput("sdrd_byte", int'(sdrd_byte), BLEN);

    sys_rst_n    = 1'b1;
    wr_fifo_used = 10'd300;
    for (int i = 0; i < 3; i++) begin
      sdram_wr_ack = 1'b1;
      #1;
      checkOutput("ack in INIT strobe", int'(wr_fifo_rd), 0);
      @(negedge clk);
    end
    sdram_wr_ack = 1'b0;
    repeat (97) @(negedge clk);
    checkOutput("init wait busy", int'(busy), 1);
    checkOutput("init wait no req", int'(sdram_wr_req), 0);

    sbQ.push_back('{1'b1, 23'd0});
    sdram_init_done = 1'b1;
    @(negedge clk);
    checkOutput("first idle busy", int'(busy), 0);
    checkOutput("first idle no req yet", int'(sdram_wr_req), 0);
    @(negedge clk);
    checkOutput("req one cycle after idle", int'(sdram_wr_req), 1);
    applyStimulus(1'b1, 1'b0, "init wr");
    checkOutput("level after first write", int'(level), 1);

    // Both eligible after a write: read goes first, then the next write.
    sbQ.push_back('{1'b0, 23'd0});
    sbQ.push_back('{1'b1, 23'd256});
    rd_enable    = 1'b1;
    rd_fifo_free = 10'd512;
    applyStimulus(1'b0, 1'b0, "prio rd");
    rd_enable = 1'b0;
    checkOutput("level after read", int'(level), 0);
    applyStimulus(1'b1, 1'b0, "prio wr");
    wr_fifo_used = 10'd0;
    checkOutput("level after prio wr", int'(level), 1);

    for (int i = 0; i < 8; i++) begin
      wr_fifo_used = 10'(vecs[i].wrUsed);
      rd_enable    = vecs[i].rdEn;
      rd_fifo_free = 10'(vecs[i].rdFree);
      if (vecs[i].expKind == 0) begin
        @(negedge clk);
        @(negedge clk);
        checkOutput($sformatf("vec%0d no req", i), int'({sdram_wr_req, sdram_rd_req}), 0);
      end else begin
        sbQ.push_back('{vecs[i].expKind == 1, 23'(vecs[i].expAddr)});
        applyStimulus(vecs[i].expKind == 1, vecs[i].gapped, $sformatf("vec%0d", i));
      end
      wr_fifo_used = 10'd0;
      rd_enable    = 1'b0;
      rd_fifo_free = 10'd0;
      checkOutput($sformatf("vec%0d level", i), int'(level), vecs[i].expLevel);
    end

    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checkOutput("flush level", int'(level), 0);
    checkOutput("flush wraddr", int'(sys_wraddr), 0);

    // Fill the 4-burst region; a flush during a burst must be ignored.
    sbQ.push_back('{1'b1, 23'd0});
    sbQ.push_back('{1'b1, 23'd256});
    sbQ.push_back('{1'b1, 23'd512});
    sbQ.push_back('{1'b1, 23'd768});
    wr_fifo_used = 10'd300;
    applyStimulus(1'b1, 1'b0, "fill0");
    fork
      applyStimulus(1'b1, 1'b0, "fill1");
      begin
        repeat (50) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
      end
    join
    checkOutput("flush mid burst ignored level", int'(level), 2);
    applyStimulus(1'b1, 1'b0, "fill2");
    applyStimulus(1'b1, 1'b0, "fill3");
    checkOutput("full level", int'(level), 4);
    repeat (5) @(negedge clk);
    checkOutput("full blocks write", int'(sdram_wr_req), 0);
    checkOutput("full idle", int'(busy), 0);

    sbQ.push_back('{1'b0, 23'd0});
    sbQ.push_back('{1'b1, 23'd0});
    rd_enable    = 1'b1;
    rd_fifo_free = 10'd512;
    applyStimulus(1'b0, 1'b0, "drain rd");
    rd_enable = 1'b0;
    applyStimulus(1'b1, 1'b0, "wrap wr");
    wr_fifo_used = 10'd0;
    checkOutput("level after wrap", int'(level), 4);

    for (int i = 0; i < 4; i++) begin
      sdram_wr_ack = 1'b1;
      sdram_rd_ack = 1'b1;
      #1;
      checkOutput("spurious ack strobe", int'({wr_fifo_rd, rd_fifo_wr}), 0);
      @(negedge clk);
    end
    sdram_wr_ack = 1'b0;
    sdram_rd_ack = 1'b0;
    checkOutput("spurious ack level", int'(level), 4);
    checkOutput("spurious ack busy", int'(busy), 0);

    // Read one burst, start a write and pull reset at 100 acks.
    sbQ.push_back('{1'b0, 23'd256});
    sbQ.push_back('{1'b1, 23'd256});
    rd_enable    = 1'b1;
    rd_fifo_free = 10'd512;
    applyStimulus(1'b0, 1'b0, "pre rst rd");
    rd_enable    = 1'b0;
    wr_fifo_used = 10'd300;
    waitCyc = 0;
    while (!sdram_wr_req && waitCyc < 8) begin
      @(negedge clk);
      waitCyc++;
    end
    checkOutput("pre rst wr req", int'(sdram_wr_req), 1);
    for (int k = 0; k < 100; k++) begin
      sdram_wr_ack = 1'b1;
      @(negedge clk);
    end
    sys_rst_n = 1'b0;
    #1;
    checkOutput("mid rst wr_req", int'(sdram_wr_req), 0);
    checkOutput("mid rst busy", int'(busy), 1);
    checkOutput("mid rst level", int'(level), 0);
    checkOutput("mid rst wraddr", int'(sys_wraddr), 0);
    checkOutput("mid rst rdaddr", int'(sys_rdaddr), 0);
    checkOutput("mid rst strobe", int'(wr_fifo_rd), 0);
    checkOutput("mid rst timeout_err", int'(timeout_err), 0);
    sdram_wr_ack = 1'b0;
    @(negedge clk);
    sys_rst_n = 1'b1;
    sbQ.push_back('{1'b1, 23'd0});
    applyStimulus(1'b1, 1'b0, "post rst wr");
    wr_fifo_used = 10'd0;
    checkOutput("post rst level", int'(level), 1);

    // Request with ack withheld.
    sbQ.push_back('{1'b1, 23'd256});
    wr_fifo_used = 10'd300;
    waitCyc = 0;
    while (!sdram_wr_req && waitCyc < 8) begin
      @(negedge clk);
      waitCyc++;
    end
    checkOutput("stall req", int'(sdram_wr_req), 1);
`ifdef SDRAM_SCHED_WATCHDOG_EN
    reqCyc = 0;
    while (sdram_wr_req && reqCyc < 3000) begin
      @(negedge clk);
      reqCyc++;
    end
    wr_fifo_used = 10'd0;
    checkOutput("watchdog req cycles", reqCyc, 1024);
    checkOutput("watchdog timeout_err", int'(timeout_err), 1);
    checkOutput("watchdog level", int'(level), 1);
    checkOutput("watchdog idle", int'(busy), 0);
    sbQ.push_back('{1'b1, 23'd256});
    wr_fifo_used = 10'd300;
    applyStimulus(1'b1, 1'b0, "retry wr");
    wr_fifo_used = 10'd0;
    checkOutput("retry timeout_err sticky", int'(timeout_err), 1);
`else
    reqCyc = 0;
    for (int k = 0; k < 2000; k++) begin
      if (sdram_wr_req) reqCyc++;
      @(negedge clk);
    end
    checkOutput("no watchdog req held", reqCyc, 2000);
    checkOutput("no watchdog req still high", int'(sdram_wr_req), 1);
    checkOutput("no watchdog timeout_err", int'(timeout_err), 0);
    applyStimulus(1'b1, 1'b0, "late ack wr");
    wr_fifo_used = 10'd0;
`endif
    checkOutput("final level", int'(level), 2);
    repeat (3) @(negedge clk);
    checkOutput("scoreboard empty", sbQ.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/sdram_burst_sched.md
SDRAM_BURST_SCHED -- requirements
Module: sdram_burst_sched

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 23'd0, meaning first word address of the circular SDRAM region.
REQ-002 SHALL have parameter DEPTH_BURSTS, default 64, meaning region size in bursts (2..32768).
REQ-003 SHALL have parameter BURST_LEN, default 256, meaning words per burst (1..256).
REQ-004 SHALL have port clk  in  1  100 MHz SDRAM reference clock; all logic on rising edge.
REQ-005 SHALL have port sys_rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports sdram_init_done in 1 (controller ready), flush in 1 (clear pointers), rd_enable in 1 (read path enabled).
REQ-007 SHALL have ports wr_fifo_used in 10 (words waiting upstream) and rd_fifo_free in 10 (free words downstream).
REQ-008 SHALL have ports sdram_wr_req out 1, sdram_rd_req out 1, sdram_wr_ack in 1, sdram_rd_ack in 1 (ack high once per transferred word).
REQ-009 SHALL have ports sys_wraddr out 23, sys_rdaddr out 23, sdwr_byte out 9, sdrd_byte out 9.
REQ-010 SHALL have ports wr_fifo_rd out 1, rd_fifo_wr out 1, busy out 1, level out 16 (bursts stored), timeout_err out 1.

Function
REQ-011 SHALL implement FSM INIT, IDLE, WR_REQ, WR_DATA, RD_REQ, RD_DATA; INIT->IDLE on first cycle sdram_init_done=1.
REQ-012 SHALL consider write eligible when wr_fifo_used>=BURST_LEN and level<DEPTH_BURSTS.
REQ-013 SHALL consider read eligible when rd_enable=1, rd_fifo_free>=BURST_LEN and level>0.
REQ-014 SHALL, in IDLE with both eligible, serve the type not served last (write first after reset/flush).
REQ-015 SHALL assert the registered req one cycle after IDLE decision, hold it until first ack cycle, deassert it the cycle after that ack.
REQ-016 SHALL hold sys_wraddr/sys_rdaddr constant from req assertion until burst end; sdwr_byte=sdrd_byte=BURST_LEN constantly.
REQ-017 SHALL count ack cycles in WR_REQ/WR_DATA (resp. RD_*); burst ends on the BURST_LEN-th ack; FSM in IDLE next cycle.
REQ-018 SHALL drive wr_fifo_rd = sdram_wr_ack AND state in {WR_REQ,WR_DATA}; rd_fifo_wr likewise for reads; zero latency.
REQ-019 SHALL ignore acks in any other state (no strobe, no count).
REQ-020 SHALL at write-burst end advance write index, level+1; read-burst end advance read index, level-1.
REQ-021 SHALL form address = BASE_ADDR + index*BURST_LEN; index wraps DEPTH_BURSTS-1 -> 0.
REQ-022 SHALL act on flush only in IDLE (indices, level, priority cleared next cycle); flush elsewhere ignored.
REQ-023 SHALL drive busy=1 in all states except IDLE; level reflects completed bursts only.

Reset
REQ-024 SHALL on sys_rst_n=0 immediately force INIT, reqs 0, addresses BASE_ADDR, indices/level/counters 0, timeout_err 0, busy 1.
REQ-025 SHALL discard any in-progress burst on reset; no partial pointer update.

Configuration
REQ-026 SHALL, with SDRAM_SCHED_WATCHDOG_EN defined, abort to IDLE if no ack within 1024 cycles of req assertion: req dropped, pointers unchanged, timeout_err set sticky until reset.
REQ-027 SHALL, without SDRAM_SCHED_WATCHDOG_EN, wait for ack indefinitely and tie timeout_err to 0.

Structure
REQ-028 SHALL place FSM state enum, ADDR_W=23, LEN_W=9 and watchdog limit 1024 in package sdram_pkg.
REQ-029 SHALL use sub-module sdram_burst_ptr (index counter, wrap, address compute), instantiated once for write, once for read.

Verification
REQ-030 Init 0 for 100 cycles then 1, wr_fifo_used=300 -> wr_req one cycle after IDLE, sys_wraddr=0, 256 wr_fifo_rd pulses, level=1.
REQ-031 level=1, wr_fifo_used=300, rd_enable=1, rd_fifo_free=512 -> read served first (write last), sys_rdaddr=0; next write at 256.
REQ-032 DEPTH_BURSTS=4, 4 writes -> sys_wraddr 0,256,512,768; level=4 blocks further writes; after one read, 5th write at 0.
REQ-033 Acks gapped (1 on/1 off) -> burst ends only on 256th ack; spurious ack in IDLE -> no fifo strobe, level unchanged.
REQ-034 Reset pulled mid WR_DATA at 100 acks -> outputs to reset values immediately; after init, write restarts at BASE_ADDR.
REQ-035 Watchdog build, ack withheld 1024 cycles -> req drops, timeout_err=1, level unchanged; without macro req held at 2000 cycles.
